// File: rtl/zone_light_pkg.sv
// Shared widths, stream FSM states and the zone level expansion for the
// zone light extractor.
package zone_light_pkg;

  localparam int unsigned ZONE_IDX_W = 9;
  localparam int unsigned LUMA_W     = 8;
  localparam int unsigned LIGHT_W    = 16;

  typedef enum logic {
    S_IDLE,
    S_SEND
  } stream_state_t;

  // Floor the zone max, then replicate the byte so 8'hFF maps to 16'hFFFF.
  function automatic logic [LIGHT_W-1:0] expand_level(
    input logic [LUMA_W-1:0] zone_max,
    input logic [LUMA_W-1:0] floor_level
  );
    logic [LUMA_W-1:0] m;
    m = (zone_max > floor_level) ? zone_max : floor_level;
    return {m, m};
  endfunction

endpackage

// File: rtl/zone_max_row.sv
// One band's worth of per-zone luma maxima plus the shadow copy that the
// stream FSM reads while the next band accumulates.
module zone_max_row
  import zone_light_pkg::*;
#(
  parameter int unsigned ZONES_X = 32,
  parameter int unsigned XW      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XW-1:0]     zx,
  input  logic [LUMA_W-1:0] luma,
  input  logic              update,
  input  logic              first,
  input  logic              capture,
  input  logic [XW-1:0]     rd_idx,
  output logic [LUMA_W-1:0] shadow_word
);

  logic [ZONES_X-1:0][LUMA_W-1:0] acc;
  logic [ZONES_X-1:0][LUMA_W-1:0] shadow;
  logic                           hit;

  assign hit = update && (first || (luma > acc[zx]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      shadow <= '0;
    end else begin
      if (hit) acc[zx] <= luma;
      // The band's last pixel lands in the same cycle as the copy, so merge it.
      if (capture) begin
        shadow <= acc;
        if (hit) shadow[zx] <= luma;
      end
    end
  end

  assign shadow_word = shadow[rd_idx];

endmodule

// File: rtl/zone_light_extract.sv
// Tracks per-zone max luma over a pixel stream and emits one 16-bit level
// per zone as each horizontal band of zones completes.
module zone_light_extract
  import zone_light_pkg::*;
#(
  parameter int unsigned       ZONE_W    = 60,
  parameter int unsigned       ZONE_H    = 67,
  parameter int unsigned       ZONES_X   = 32,
  parameter int unsigned       ZONES_Y   = 16,
  parameter logic [LUMA_W-1:0] MIN_LEVEL = 8'd4
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  input  logic                  pix_valid,
  input  logic                  pix_sof,
  input  logic                  pix_eol,
  input  logic [LUMA_W-1:0]     pix_luma,
  output logic [LIGHT_W-1:0]    light,
  output logic [ZONE_IDX_W-1:0] light_index,
  output logic                  light_refresh,
  output logic                  frame_done,
  output logic                  overrun
);

  localparam int unsigned XSW = (ZONE_W  > 1) ? $clog2(ZONE_W)  : 1;
  localparam int unsigned XW  = (ZONES_X > 1) ? $clog2(ZONES_X) : 1;
  localparam int unsigned YSW = (ZONE_H  > 1) ? $clog2(ZONE_H)  : 1;
  localparam int unsigned YW  = (ZONES_Y > 1) ? $clog2(ZONES_Y) : 1;

  logic [XSW-1:0] x_sub, x_sub_cur, x_sub_nxt;
  logic [XW-1:0]  zx, zx_cur, zx_nxt;
  logic           x_over, x_over_cur, x_over_nxt;
  logic [YSW-1:0] y_sub, y_sub_cur, y_sub_nxt;
  logic [YW-1:0]  zy, zy_cur, zy_nxt;
  logic           y_over, y_over_cur, y_over_nxt;

  logic sof_hit, update, first, band_done, capture;

  stream_state_t     state, state_nxt;
  logic [XW-1:0]     send_idx, send_idx_nxt;
  logic [YW-1:0]     cap_zy;
  logic [LUMA_W-1:0] shadow_word;

  assign sof_hit = pix_valid && pix_sof;

  // Position of the pixel currently presented; a start-of-frame pixel is (0,0).
  always_comb begin
    x_sub_cur  = sof_hit ? '0   : x_sub;
    zx_cur     = sof_hit ? '0   : zx;
    x_over_cur = sof_hit ? 1'b0 : x_over;
    y_sub_cur  = sof_hit ? '0   : y_sub;
    zy_cur     = sof_hit ? '0   : zy;
    y_over_cur = sof_hit ? 1'b0 : y_over;
  end

  assign update    = pix_valid && !x_over_cur && !y_over_cur;
  assign first     = (x_sub_cur == '0) && (y_sub_cur == '0);
  assign band_done = pix_valid && pix_eol && !y_over_cur
                     && (y_sub_cur == YSW'(ZONE_H - 1));
  assign capture   = band_done && (state == S_IDLE);

  always_comb begin
    x_sub_nxt  = x_sub;
    zx_nxt     = zx;
    x_over_nxt = x_over;
    y_sub_nxt  = y_sub;
    zy_nxt     = zy;
    y_over_nxt = y_over;
    if (pix_valid) begin
      y_sub_nxt  = y_sub_cur;
      zy_nxt     = zy_cur;
      y_over_nxt = y_over_cur;
      if (pix_eol) begin
        x_sub_nxt  = '0;
        zx_nxt     = '0;
        x_over_nxt = 1'b0;
        if (!y_over_cur) begin
          if (y_sub_cur == YSW'(ZONE_H - 1)) begin
            y_sub_nxt = '0;
            if (zy_cur == YW'(ZONES_Y - 1)) y_over_nxt = 1'b1;
            else                            zy_nxt     = zy_cur + YW'(1);
          end else begin
            y_sub_nxt = y_sub_cur + YSW'(1);
          end
        end
      end else begin
        x_sub_nxt  = x_sub_cur;
        zx_nxt     = zx_cur;
        x_over_nxt = x_over_cur;
        if (!x_over_cur) begin
          if (x_sub_cur == XSW'(ZONE_W - 1)) begin
            x_sub_nxt = '0;
            if (zx_cur == XW'(ZONES_X - 1)) x_over_nxt = 1'b1;
            else                            zx_nxt     = zx_cur + XW'(1);
          end else begin
            x_sub_nxt = x_sub_cur + XSW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      x_sub  <= '0;
      zx     <= '0;
      x_over <= 1'b0;
      y_sub  <= '0;
      zy     <= '0;
      y_over <= 1'b0;
    end else begin
      x_sub  <= x_sub_nxt;
      zx     <= zx_nxt;
      x_over <= x_over_nxt;
      y_sub  <= y_sub_nxt;
      zy     <= zy_nxt;
      y_over <= y_over_nxt;
    end
  end

  zone_max_row #(
    .ZONES_X (ZONES_X),
    .XW      (XW)
  ) u_row (
    .clk         (I_clk),
    .rst         (I_rst),
    .zx          (zx_cur),
    .luma        (pix_luma),
    .update      (update),
    .first       (first),
    .capture     (capture),
    .rd_idx      (send_idx),
    .shadow_word (shadow_word)
  );

  always_comb begin
    state_nxt    = state;
    send_idx_nxt = send_idx;
    case (state)
      S_IDLE: begin
        if (capture) begin
          state_nxt    = S_SEND;
          send_idx_nxt = '0;
        end
      end
      S_SEND: begin
        if (send_idx == XW'(ZONES_X - 1)) state_nxt    = S_IDLE;
        else                              send_idx_nxt = send_idx + XW'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state    <= S_IDLE;
      send_idx <= '0;
      cap_zy   <= '0;
    end else begin
      state    <= state_nxt;
      send_idx <= send_idx_nxt;
      if (capture) cap_zy <= zy_cur;
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      light         <= '0;
      light_index   <= '0;
      light_refresh <= 1'b0;
      frame_done    <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      light_refresh <= (state == S_SEND);
      frame_done    <= (state == S_SEND) && (cap_zy == YW'(ZONES_Y - 1))
                       && (send_idx == XW'(ZONES_X - 1));
      if (state == S_SEND) begin
        light       <= expand_level(shadow_word, MIN_LEVEL);
        light_index <= ZONE_IDX_W'(cap_zy) * ZONE_IDX_W'(ZONES_X)
                       + ZONE_IDX_W'(send_idx);
      end
      if (sof_hit) overrun <= 1'b0;
      if (band_done && (state == S_SEND)) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_zone_light_extract.sv
// Scoreboard bench for zone_light_extract on a reduced 8x4 zone grid of
// 4x2-pixel tiles, checked against a per-band max-luma reference model.
module tb_zone_light_extract;

  localparam int ZW = 4, ZH = 2, ZX = 8, ZY = 4;
  localparam int MINL = 4;
  localparam int FW = ZW * ZX, FH = ZH * ZY;

  typedef struct {
    int idx;
    int lvl;
    int fd;
    int when;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_valid = 1'b0, pix_sof = 1'b0, pix_eol = 1'b0;
  logic [7:0]  pix_luma = '0;
  logic [15:0] light;
  logic [8:0]  light_index;
  logic        light_refresh, frame_done, overrun;

  zone_light_extract #(
    .ZONE_W    (ZW),
    .ZONE_H    (ZH),
    .ZONES_X   (ZX),
    .ZONES_Y   (ZY),
    .MIN_LEVEL (8'd4)
  ) dut (
    .I_clk         (clk),
    .I_rst         (rst),
    .pix_valid     (pix_valid),
    .pix_sof       (pix_sof),
    .pix_eol       (pix_eol),
    .pix_luma      (pix_luma),
    .light         (light),
    .light_index   (light_index),
    .light_refresh (light_refresh),
    .frame_done    (frame_done),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   errors = 0, checks = 0;
  exp_t q[$];

  // Reference model state: raster position, per-zone max of the open band.
  int mx, my;
  int zmax[ZX];
  int last_cap = -1000;
  bit exp_ovr = 1'b0;
  bit allow_gap = 1'b0;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endfunction

  function automatic int level_of(int m);
    int f;
    f = (m < MINL) ? MINL : m;
    return f * 257;
  endfunction

  function automatic void clear_band();
    foreach (zmax[i]) zmax[i] = 0;
  endfunction

  // Band accepted at edge k: stream entries appear at k+1 .. k+ZX unless a
  // previous stream still occupies the ZX cycles after its own capture.
  function automatic void band_done(int zy, int k);
    exp_t e;
    if (k - last_cap <= ZX) begin
      exp_ovr = 1'b1;
    end else begin
      for (int i = 0; i < ZX; i++) begin
        e.idx  = zy * ZX + i;
        e.lvl  = level_of(zmax[i]);
        e.fd   = (zy == ZY - 1 && i == ZX - 1) ? 1 : 0;
        e.when = k + 1 + i;
        q.push_back(e);
      end
      last_cap = k;
    end
    clear_band();
  endfunction

  function automatic int pix_val(int mode, int x, int y);
    case (mode)
      0:       return 100;
      1:       return (x == 5 && y == 2) ? 255 : 0;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic send_px(input int luma, input bit sof, input bit eol);
    int k;
    @(negedge clk);
    if (allow_gap && $urandom_range(0, 3) == 0) begin
      pix_valid = 1'b0;
      @(negedge clk);
    end
    pix_valid = 1'b1;
    pix_sof   = sof;
    pix_eol   = eol;
    pix_luma  = 8'(luma);
    k = cyc + 1;
    if (sof) begin
      mx = 0;
      my = 0;
      clear_band();
      exp_ovr = 1'b0;
    end
    if (mx < FW && my < FH && luma > zmax[mx / ZW]) zmax[mx / ZW] = luma;
    if (eol) begin
      if (my < FH && (my % ZH) == ZH - 1) band_done(my / ZH, k);
      mx = 0;
      my++;
    end else begin
      mx++;
    end
  endtask

  task automatic send_line(input int len, input int mode, input bit sof_first);
    int y;
    y = sof_first ? 0 : my;
    for (int x = 0; x < len; x++)
      send_px(pix_val(mode, x, y), sof_first && x == 0, x == len - 1);
  endtask

  task automatic send_frame(input int mode, input int extra_x, input int extra_y);
    int lines;
    lines = FH + int'($urandom_range(0, extra_y));
    for (int l = 0; l < lines; l++)
      send_line(FW + int'($urandom_range(0, extra_x)), mode, l == 0);
  endtask

  task automatic idle();
    @(negedge clk);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_eol   = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    idle();
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries missing, expected 0 outstanding", q.size());
      q.delete();
    end
    check("overrun", int'(overrun), int'(exp_ovr));
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (light_refresh) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got index %0d light 0x%0h, expected no strobe",
                   light_index, light);
        end else begin
          e = q.pop_front();
          check("light_index",  int'(light_index), e.idx);
          check("light",        int'(light),       e.lvl);
          check("frame_done",   int'(frame_done),  e.fd);
          check("strobe_cycle", cyc,               e.when);
        end
      end else if (frame_done) begin
        check("frame_done_without_strobe", int'(frame_done), 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    repeat (3) @(negedge clk);
    check("rst_light",         int'(light),         0);
    check("rst_light_index",   int'(light_index),   0);
    check("rst_light_refresh", int'(light_refresh), 0);
    check("rst_frame_done",    int'(frame_done),    0);
    check("rst_overrun",       int'(overrun),       0);
    rst = 1'b0;

    // Flat frame and single bright pixel with floor everywhere else.
    send_frame(0, 0, 0);
    wait_drain();
    send_frame(1, 0, 0);
    wait_drain();

    // Random luma, idle gaps, pixels and lines past the zone grid.
    allow_gap = 1'b1;
    repeat (3) begin
      send_frame(2, 3, 2);
      wait_drain();
    end

    // Short lines: second band completes while the first is still streaming.
    allow_gap = 1'b0;
    send_line(FW, 2, 1'b1);
    send_line(FW, 2, 1'b0);
    send_line(2, 2, 1'b0);
    send_line(2, 2, 1'b0);
    wait_drain();
    check("overrun_set", int'(overrun), 1);
    send_frame(2, 0, 0);
    wait_drain();
    check("overrun_cleared", int'(overrun), 0);

    // Partial band abandoned by a new start of frame.
    allow_gap = 1'b1;
    send_line(FW, 2, 1'b1);
    send_frame(2, 1, 0);
    wait_drain();

    // Reset while entry 10 (band 1, zone 2) is on the port.
    allow_gap = 1'b0;
    for (int l = 0; l < 2 * ZH; l++) send_line(FW, 2, l == 0);
    idle();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      #2;
      if (light_refresh && light_index == 9'd10) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_wait: got no entry 10 within 100 cycles, expected one");
    end
    rst = 1'b1;
    #1;
    check("midrst_light_refresh", int'(light_refresh), 0);
    check("midrst_light",         int'(light),         0);
    check("midrst_light_index",   int'(light_index),   0);
    check("midrst_frame_done",    int'(frame_done),    0);
    q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    last_cap = -1000;
    exp_ovr = 1'b0;
    repeat (30) @(negedge clk);
    check("post_rst_overrun", int'(overrun), 0);

    allow_gap = 1'b1;
    send_frame(2, 2, 1);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
